// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//   Plays a song stored in an internal note table by driving the two-track
//   tone generator: tone codes, a play gate and per-track chip selects.
//   Each table entry is {dur, tone2, tone1}; dur counts ticks of TICK_DIV
//   clock cycles and dur == 0 marks the end of the song. Every note is
//   followed by GAP_TICKS silent ticks.
//
// Parameters
//   TICK_DIV   clk cycles per duration tick
//   GAP_TICKS  silent ticks after every note (0 = no gap)
//   AW         note-table address width (2**AW entries)
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   start, stop      pulses: begin song at entry 0 / abort song
//   pause            level: freeze the current note/gap while high
//   track_sel        {enable track 2, enable track 1}, sampled on start
//   wr_en/addr/data  note-table write port (usable at any time)
//   tonos_cancion1/2 track tone codes
//   play             note gate
//   CS1, CS2         track enables
//   busy             high while a song is being fetched or played
//   done             one-cycle pulse on song completion
//
// Build option
//   SEQ_LOOP_EN      when defined, the song restarts at entry 0 at its end
//                    instead of finishing (runs until stop).
// ---------------------------------------------------------------------------
module song_sequencer #(
  parameter int TICK_DIV  = 16000,
  parameter int GAP_TICKS = 10,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [1:0]    track_sel,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic [7:0]    tonos_cancion1,
  output logic [7:0]    tonos_cancion2,
  output logic          play,
  output logic          CS1,
  output logic          CS2,
  output logic          busy,
  output logic          done
);

  localparam int            DEPTH    = 1 << AW;
  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;
  localparam logic [AW:0]   IDX_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  // One extra index bit flags "walked past the last entry".
  logic [AW:0]   idx_q, idx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    tick_q, tick_d;
  logic [7:0]    dur_q, dur_d;
  logic [7:0]    tone1_q, tone1_d;
  logic [7:0]    tone2_q, tone2_d;
  logic [1:0]    cs_q, cs_d;
  logic          play_q, play_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Note table: one write port, one synchronous read port.
  logic [23:0]   mem [DEPTH];
  logic [23:0]   rd_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  // The read is issued on the edge that enters FETCH, so FETCH sees the
  // entry in rd_q. A write on that same edge leaves rd_q with the old data.
  assign rd_en   = (state_d == S_FETCH);
  assign rd_addr = idx_d[AW-1:0];

  // NOTE: table storage and its read register carry no reset; only control
  // state is cleared, so a reset never wipes a loaded song.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    tone1_d = tone1_q;
    tone2_d = tone2_q;
    cs_d    = cs_q;
    play_d  = play_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && (track_sel != 2'b00)) begin
          cs_d    = track_sel;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (idx_q[AW] || (rd_q[23:16] == 8'd0)) begin
`ifdef SEQ_LOOP_EN
          // Restart from entry 0, unless entry 0 itself is the end marker.
          if (idx_q != '0) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cs_d    = 2'b00;
            tone1_d = 8'd0;
            tone2_d = 8'd0;
            play_d  = 1'b0;
          end
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          cs_d    = 2'b00;
          tone1_d = 8'd0;
          tone2_d = 8'd0;
          play_d  = 1'b0;
`endif
        end else begin
          tone1_d = rd_q[7:0];
          tone2_d = rd_q[15:8];
          dur_d   = rd_q[23:16];
          pre_d   = '0;
          tick_d  = 8'd0;
          play_d  = 1'b1;
          state_d = S_NOTE;
        end
      end

      S_NOTE: begin
        // Pause freezes both counters and mutes the gate.
        play_d = !pause;
        if (!pause) begin
          if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = tick_q + 8'd1;
            if (tick_q == dur_q - 8'd1) begin
              play_d = 1'b0;
              tick_d = 8'd0;
              if (GAP_TICKS > 0) begin
                state_d = S_GAP;
              end else begin
                idx_d   = idx_q + IDX_ONE;
                state_d = S_FETCH;
              end
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
      end

      S_GAP: begin
        if (!pause) begin
          if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = tick_q + 8'd1;
            if (tick_q == GAP_LAST) begin
              tick_d  = 8'd0;
              idx_d   = idx_q + IDX_ONE;
              state_d = S_FETCH;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cs_d    = 2'b00;
      tone1_d = 8'd0;
      tone2_d = 8'd0;
      play_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_NOTE) || (state_d == S_GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 8'd0;
      dur_q   <= 8'd0;
      tone1_q <= 8'd0;
      tone2_q <= 8'd0;
      cs_q    <= 2'b00;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      tone1_q <= tone1_d;
      tone2_q <= tone2_d;
      cs_q    <= cs_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tonos_cancion1 = tone1_q;
  assign tonos_cancion2 = tone2_q;
  assign play           = play_q;
  assign CS1            = cs_q[0];
  assign CS2            = cs_q[1];
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
